// File: rtl/sw_debouncer.sv
// Switch/button conditioner: two-FF synchroniser, bounce filter, and registered
// press/release/long-press pulses plus a press-toggled bit.
module sw_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_sw_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse,
    output logic o_toggle
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic sync1, sync2;
    logic [DB_W-1:0] db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic long_done, long_done_nxt;
    logic hold_run;
    logic level_nxt, press_nxt, release_nxt, long_nxt, toggle_nxt;

    always_comb begin
        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        hold_cnt_nxt  = hold_cnt;
        long_done_nxt = long_done;
        level_nxt     = o_sw_level;
        toggle_nxt    = o_toggle;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
        hold_run      = 1'b0;

        case (state)
            IDLE_LOW: begin
                if (sync2) begin
                    state_nxt  = WAIT_HIGH;
                    db_cnt_nxt = DB_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_nxt = IDLE_LOW;
                end else if (db_cnt == DB_MAX) begin
                    state_nxt     = STABLE_HIGH;
                    level_nxt     = 1'b1;
                    press_nxt     = 1'b1;
                    toggle_nxt    = ~o_toggle;
                    hold_cnt_nxt  = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            STABLE_HIGH: begin
                hold_run = 1'b1;
                if (!sync2) begin
                    state_nxt  = WAIT_LOW;
                    db_cnt_nxt = DB_W'(1);
                end
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_nxt = STABLE_HIGH;
                    hold_run  = 1'b1;
                end else if (db_cnt == DB_MAX) begin
                    // Accepted release freezes the hold timer so a long pulse cannot follow it.
                    state_nxt   = IDLE_LOW;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                    hold_run   = 1'b1;
                end
            end
            default: state_nxt = IDLE_LOW;
        endcase

        if (hold_run) begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end else if (!long_done) begin
                long_nxt      = 1'b1;
                long_done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1           <= 1'b0;
            sync2           <= 1'b0;
            state           <= IDLE_LOW;
            db_cnt          <= '0;
            hold_cnt        <= '0;
            long_done       <= 1'b0;
            o_sw_level      <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            o_long_pulse    <= 1'b0;
            o_toggle        <= 1'b0;
        end else begin
            sync1           <= i_sw;
            sync2           <= sync1;
            state           <= state_nxt;
            db_cnt          <= db_cnt_nxt;
            hold_cnt        <= hold_cnt_nxt;
            long_done       <= long_done_nxt;
            o_sw_level      <= level_nxt;
            o_press_pulse   <= press_nxt;
            o_release_pulse <= release_nxt;
            o_long_pulse    <= long_nxt;
            o_toggle        <= toggle_nxt;
        end
    end

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer: run-length reference model checked every cycle,
// plus literal expectations at the key edges of each scenario.
module tb_sw_debouncer;

    localparam int D = 4;
    localparam int L = 20;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_sw  = 1'b0;
    logic o_sw_level, o_press_pulse, o_release_pulse, o_long_pulse, o_toggle;

    int vectors = 0;
    int miscompares = 0;

    sw_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_sw(i_sw),
        .o_sw_level(o_sw_level),
        .o_press_pulse(o_press_pulse),
        .o_release_pulse(o_release_pulse),
        .o_long_pulse(o_long_pulse),
        .o_toggle(o_toggle)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the filter sees the pin two edges late and flips its level
    // after D+1 consecutive disagreeing samples; long press fires L+1 edges after a press.
    bit m_valid = 0;
    bit m_s1, m_s2, m_level, m_press, m_release, m_long, m_toggle;
    int m_run, m_age;

    always @(posedge i_clk) begin
        bit x;
        if (i_rst) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_toggle = 0;
            m_press = 0; m_release = 0; m_long = 0;
            m_run = 0; m_age = 0; m_valid = 1;
        end else begin
            x = m_s2;
            m_s2 = m_s1;
            m_s1 = i_sw;
            m_press = 0; m_release = 0; m_long = 0;
            if (m_level) m_age++;
            if (x != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_run = 0;
                    m_level = x;
                    if (x) begin
                        m_press = 1;
                        m_toggle = !m_toggle;
                        m_age = 0;
                    end else begin
                        m_release = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
            if (m_level && m_age == L + 1) m_long = 1;
        end
    end

    always @(negedge i_clk) begin
        if (m_valid) begin
            chk("level", o_sw_level, m_level);
            chk("press", o_press_pulse, m_press);
            chk("release", o_release_pulse, m_release);
            chk("long", o_long_pulse, m_long);
            chk("toggle", o_toggle, m_toggle);
        end
    end

    task automatic step(input logic sw, input logic rst);
        i_sw  = sw;
        i_rst = rst;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        step(0, 1); step(0, 1);
        chk("rst_level", o_sw_level, 1'b0);
        chk("rst_toggle", o_toggle, 1'b0);
        repeat (5) step(0, 0);

        // Clean press, then long hold
        step(1, 0);
        repeat (5) step(1, 0);
        chk("s1_press_early", o_press_pulse, 1'b0);
        chk("s1_level_early", o_sw_level, 1'b0);
        step(1, 0);
        chk("s1_press", o_press_pulse, 1'b1);
        chk("s1_level", o_sw_level, 1'b1);
        chk("s1_toggle", o_toggle, 1'b1);
        repeat (20) step(1, 0);
        chk("s4_long_early", o_long_pulse, 1'b0);
        step(1, 0);
        chk("s4_long", o_long_pulse, 1'b1);
        step(1, 0);
        chk("s4_long_end", o_long_pulse, 1'b0);
        repeat (20) step(1, 0);

        // Clean release
        repeat (6) step(0, 0);
        chk("s3_release_early", o_release_pulse, 1'b0);
        chk("s3_level_early", o_sw_level, 1'b1);
        step(0, 0);
        chk("s3_release", o_release_pulse, 1'b1);
        chk("s3_level", o_sw_level, 1'b0);
        chk("s3_toggle", o_toggle, 1'b1);
        step(0, 0);
        chk("s3_release_end", o_release_pulse, 1'b0);
        repeat (4) step(0, 0);

        // Bounce then held high; second press gets its own long pulse
        step(1, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(1, 0);
        repeat (5) step(1, 0);
        chk("s2_press_early", o_press_pulse, 1'b0);
        chk("s2_level_early", o_sw_level, 1'b0);
        step(1, 0);
        chk("s2_press", o_press_pulse, 1'b1);
        chk("s2_toggle", o_toggle, 1'b0);
        repeat (20) step(1, 0);
        chk("s4b_long_early", o_long_pulse, 1'b0);
        step(1, 0);
        chk("s4b_long", o_long_pulse, 1'b1);
        repeat (5) step(1, 0);
        repeat (12) step(0, 0);

        // Short press of exactly 10 cycles
        repeat (7) step(1, 0);
        chk("s6_press", o_press_pulse, 1'b1);
        chk("s6_toggle", o_toggle, 1'b1);
        repeat (3) step(1, 0);
        repeat (6) step(0, 0);
        chk("s6_release_early", o_release_pulse, 1'b0);
        step(0, 0);
        chk("s6_release", o_release_pulse, 1'b1);
        repeat (30) step(0, 0);

        // Reset while qualifying a press with db_cnt at 3
        repeat (5) step(1, 0);
        chk("s5_toggle_before", o_toggle, 1'b1);
        step(1, 1);
        chk("s5_rst_toggle", o_toggle, 1'b0);
        chk("s5_rst_level", o_sw_level, 1'b0);
        chk("s5_rst_press", o_press_pulse, 1'b0);
        step(1, 0);
        repeat (5) step(1, 0);
        chk("s5_press_early", o_press_pulse, 1'b0);
        step(1, 0);
        chk("s5_press", o_press_pulse, 1'b1);
        chk("s5_toggle", o_toggle, 1'b1);
        repeat (3) step(1, 0);
        repeat (12) step(0, 0);

        // Release accepted on the edge the hold timer reaches L: no long pulse
        step(1, 0);
        repeat (5) step(1, 0);
        step(1, 0);
        chk("s7_press", o_press_pulse, 1'b1);
        chk("s7_toggle", o_toggle, 1'b0);
        repeat (13) step(1, 0);
        repeat (6) step(0, 0);
        chk("s7_level_held", o_sw_level, 1'b1);
        step(0, 0);
        chk("s7_release", o_release_pulse, 1'b1);
        chk("s7_long_at_release", o_long_pulse, 1'b0);
        step(0, 0);
        chk("s7_long_suppressed", o_long_pulse, 1'b0);
        repeat (5) step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
